pwm_frame_scheduler: RTL and testbench
======================================

PWM_FRAME_SCHEDULER -- requirements
Module: pwm_frame_scheduler

Interface
REQ-001 SHALL have parameter INPUT_BIT_WIDTH, default 10, width of motor values and high_counter.
REQ-002 SHALL have parameter FAILSAFE_FRAMES, default 5, the number of frames without an update before failsafe triggers.
REQ-003 SHALL have port us_clk, input, 1, 1 MHz clock.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports motor_1_val..motor_4_val, input, INPUT_BIT_WIDTH each, requested throttle in us above minimum.
REQ-006 SHALL have port update_req, input, 1, level request: new motor values are valid and stable.
REQ-007 SHALL have port update_ack, output, 1, one-cycle pulse when the values are captured.
REQ-008 SHALL have port arm, input, 1, motors enabled when high.
REQ-009 SHALL have port period_counter, output, 16, microsecond position in frame, shared by all generators.
REQ-010 SHALL have port high_counter, output, INPUT_BIT_WIDTH, microseconds elapsed past the minimum high time.
REQ-011 SHALL have ports motor_1_out..motor_4_out, output, INPUT_BIT_WIDTH each, per-frame values driven to the generators.
REQ-012 SHALL have port frame_start, output, 1, one-cycle pulse at period_counter == 0.
REQ-013 SHALL have port state_out, output, 2, current state: 00 DISARMED, 01 ARMED, 10 FAILSAFE.

Function
REQ-014 SHALL use `MIN_PWM_TIME_HIGH_US (1000), `MAX_PWM_TIME_HIGH_US (2000) and `PWM_PERIOD_US (20000) from common_defines.v.
REQ-015 period_counter SHALL increment every us_clk and wrap from `PWM_PERIOD_US to 0, giving a frame of PERIOD+1 cycles.
REQ-016 high_counter SHALL be 0 while period_counter <= MIN.
REQ-017 high_counter SHALL equal period_counter - MIN for MIN < period_counter <= MAX.
REQ-018 high_counter SHALL hold MAX-MIN (1000) while period_counter > MAX, and return to 0 on wrap.
REQ-019 frame_start SHALL assert in the cycle where period_counter == 0.
REQ-020 The frame boundary SHALL be the cycle where period_counter == PERIOD; all captures and state changes take effect there, so outputs never change mid-frame.
REQ-021 At a boundary with update_req high, motor values SHALL be captured into shadow registers and update_ack pulsed for exactly that cycle.
REQ-022 update_req low at a boundary SHALL retain the previous shadow values; the requester holds update_req and values until update_ack.
REQ-023 Captured values SHALL be clamped to MAX-MIN (1000); inputs 1001..1023 capture as 1000.
REQ-024 The state machine SHALL move DISARMED->ARMED at a boundary when arm=1, and ARMED->DISARMED at a boundary when arm=0.
REQ-025 The state machine SHALL move FAILSAFE->DISARMED at a boundary only when arm=0.
REQ-026 motor_N_out SHALL equal shadow values only in ARMED; in DISARMED and FAILSAFE they SHALL be 0.
REQ-027 arm toggling mid-frame SHALL have no effect until the boundary; only the level at the boundary matters.
REQ-028 When update_req and an arm change coincide at one boundary, both SHALL apply together, with new values used in the first armed frame.

Reset
REQ-029 On resetn low, immediately: period_counter=0, high_counter=0, shadow values=0, motor_N_out=0, update_ack=0, frame_start=0, state=DISARMED.
REQ-030 Reset mid-frame SHALL abort the frame; after release, counting restarts from 0 and frame_start is asserted in the first cycle after release.

Configuration
REQ-031 Macro PWM_FAILSAFE_EN SHALL, when defined, count consecutive boundaries without update_req while ARMED.
REQ-032 With PWM_FAILSAFE_EN defined, reaching FAILSAFE_FRAMES SHALL move ARMED->FAILSAFE, and any capture SHALL clear the count.
REQ-033 Without PWM_FAILSAFE_EN, no counter SHALL exist, FAILSAFE SHALL be unreachable and state_out never equals 10.

Verification
REQ-034 Release reset, arm=0 -> frame_start at cycles 0, 20001, 40002; motor outs 0; state 00.
REQ-035 arm=1 and update_req with vals 500/0/1000/1023 -> ack at period_counter=20000; next frame outs 500/0/1000/1000.
REQ-036 Within a frame, high_counter reads 0 at pc=1000, 1 at 1001, 1000 at 2000, and 1000 at 19999.
REQ-037 Drop arm at pc=5000 -> outs unchanged until pc=20000, then 0 and state 00.
REQ-038 PWM_FAILSAFE_EN, armed, no update_req for 5 boundaries -> state 10, outs 0; arm=0 at next boundary -> state 00.
REQ-039 Assert resetn low at pc=12345 -> all outputs 0 immediately; after release, pc counts 0,1,2.

Source files
------------

// File: rtl/pwm_frame_scheduler.sv
// Frame timer, shadow-register update handshake and arm state machine for four PWM generators.
// Define PWM_FAILSAFE_EN to add the missed-update failsafe (ARMED -> FAILSAFE).

`ifndef MIN_PWM_TIME_HIGH_US
`define MIN_PWM_TIME_HIGH_US 1000
`endif
`ifndef MAX_PWM_TIME_HIGH_US
`define MAX_PWM_TIME_HIGH_US 2000
`endif
`ifndef PWM_PERIOD_US
`define PWM_PERIOD_US 20000
`endif

module pwm_frame_scheduler #(
    parameter int unsigned INPUT_BIT_WIDTH = 10,
    parameter int unsigned FAILSAFE_FRAMES = 5
) (
    input  logic                       us_clk,
    input  logic                       resetn,
    input  logic [INPUT_BIT_WIDTH-1:0] motor_1_val,
    input  logic [INPUT_BIT_WIDTH-1:0] motor_2_val,
    input  logic [INPUT_BIT_WIDTH-1:0] motor_3_val,
    input  logic [INPUT_BIT_WIDTH-1:0] motor_4_val,
    input  logic                       update_req,
    output logic                       update_ack,
    input  logic                       arm,
    output logic [15:0]                period_counter,
    output logic [INPUT_BIT_WIDTH-1:0] high_counter,
    output logic [INPUT_BIT_WIDTH-1:0] motor_1_out,
    output logic [INPUT_BIT_WIDTH-1:0] motor_2_out,
    output logic [INPUT_BIT_WIDTH-1:0] motor_3_out,
    output logic [INPUT_BIT_WIDTH-1:0] motor_4_out,
    output logic                       frame_start,
    output logic [1:0]                 state_out
);

    localparam int unsigned  W      = INPUT_BIT_WIDTH;
    localparam logic [15:0]  PERIOD = 16'(`PWM_PERIOD_US);
    localparam logic [15:0]  MIN_US = 16'(`MIN_PWM_TIME_HIGH_US);
    localparam logic [15:0]  MAX_US = 16'(`MAX_PWM_TIME_HIGH_US);
    localparam logic [W-1:0] SPAN   = W'(`MAX_PWM_TIME_HIGH_US - `MIN_PWM_TIME_HIGH_US);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_FAILSAFE = 2'b10
    } state_t;

    logic [15:0]       pc_q, pc_d;
    logic [W-1:0]      hc_q, hc_d;
    logic              ack_q, ack_d;
    logic [3:0][W-1:0] shadow_q, shadow_d;
    logic [3:0][W-1:0] out_q, out_d;
    logic [3:0][W-1:0] val_c;
    state_t            state_q, state_d;
    logic              boundary_c;
    logic              fail_trip_c;

`ifdef PWM_FAILSAFE_EN
    localparam int unsigned MISS_W = $clog2(FAILSAFE_FRAMES + 1);
    logic [MISS_W-1:0] miss_q, miss_d;
`else
    logic unused_failsafe_frames_c;
    assign unused_failsafe_frames_c = (FAILSAFE_FRAMES != 0);
`endif

    assign val_c = {motor_4_val, motor_3_val, motor_2_val, motor_1_val};

    // Everything is decided on the edge that enters the last cycle of the frame (pc == PERIOD).
    always_comb begin
        pc_d        = (pc_q == PERIOD) ? 16'd0 : pc_q + 16'd1;
        boundary_c  = (pc_d == PERIOD);
        hc_d        = '0;
        if (pc_d > MAX_US) begin
            hc_d = SPAN;
        end else if (pc_d > MIN_US) begin
            hc_d = W'(pc_d - MIN_US);
        end
        ack_d       = boundary_c & update_req;
        shadow_d    = shadow_q;
        fail_trip_c = 1'b0;
        if (ack_d) begin
            for (int i = 0; i < 4; i++) begin
                shadow_d[i] = (val_c[i] > SPAN) ? SPAN : val_c[i];
            end
        end
`ifdef PWM_FAILSAFE_EN
        miss_d = miss_q;
        if (boundary_c) begin
            if (update_req || (state_q != ST_ARMED)) begin
                miss_d = '0;
            end else begin
                miss_d = miss_q + MISS_W'(1);
            end
        end
        fail_trip_c = boundary_c && (state_q == ST_ARMED) && !update_req
                      && ((32'(miss_q) + 32'd1) >= FAILSAFE_FRAMES);
`endif
        state_d = state_q;
        if (boundary_c) begin
            case (state_q)
                ST_DISARMED: if (arm) state_d = ST_ARMED;
                ST_ARMED: begin
                    if (!arm) begin
                        state_d = ST_DISARMED;
                    end else if (fail_trip_c) begin
                        state_d = ST_FAILSAFE;
                    end
                end
                ST_FAILSAFE: if (!arm) state_d = ST_DISARMED;
                default:     state_d = ST_DISARMED;
            endcase
        end
        out_d = (state_d == ST_ARMED) ? shadow_d : '0;
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            pc_q     <= '0;
            hc_q     <= '0;
            ack_q    <= 1'b0;
            shadow_q <= '0;
            out_q    <= '0;
            state_q  <= ST_DISARMED;
`ifdef PWM_FAILSAFE_EN
            miss_q   <= '0;
`endif
        end else begin
            pc_q     <= pc_d;
            hc_q     <= hc_d;
            ack_q    <= ack_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            state_q  <= state_d;
`ifdef PWM_FAILSAFE_EN
            miss_q   <= miss_d;
`endif
        end
    end

    assign period_counter = pc_q;
    assign high_counter   = hc_q;
    assign update_ack     = ack_q;
    assign motor_1_out    = out_q[0];
    assign motor_2_out    = out_q[1];
    assign motor_3_out    = out_q[2];
    assign motor_4_out    = out_q[3];
    assign state_out      = state_q;
    // Decoded so it is low during reset yet high in the very first cycle after release.
    assign frame_start    = resetn & (pc_q == 16'd0);

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Self-checking bench for pwm_frame_scheduler: frame-level reference model compared every cycle,
// plus literal checkpoints for reset, capture/clamp, arm timing and mid-frame reset.

module tb_pwm_frame_scheduler;

    localparam int W      = 10;
    localparam int PERIOD = 20000;
    localparam int FRAME  = PERIOD + 1;
    localparam int MIN_US = 1000;
    localparam int MAX_US = 2000;
    localparam int SPAN   = MAX_US - MIN_US;
`ifdef PWM_FAILSAFE_EN
    localparam int FS_FRAMES = 1;
`else
    localparam int FS_FRAMES = 5;
`endif

    logic         us_clk = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] v1 = '0, v2 = '0, v3 = '0, v4 = '0;
    logic         update_req = 1'b0;
    logic         arm = 1'b0;
    logic         update_ack;
    logic [15:0]  period_counter;
    logic [W-1:0] high_counter;
    logic [W-1:0] motor_1_out, motor_2_out, motor_3_out, motor_4_out;
    logic         frame_start;
    logic [1:0]   state_out;

    pwm_frame_scheduler #(
        .INPUT_BIT_WIDTH(W),
        .FAILSAFE_FRAMES(FS_FRAMES)
    ) dut (
        .us_clk         (us_clk),
        .resetn         (resetn),
        .motor_1_val    (v1),
        .motor_2_val    (v2),
        .motor_3_val    (v3),
        .motor_4_val    (v4),
        .update_req     (update_req),
        .update_ack     (update_ack),
        .arm            (arm),
        .period_counter (period_counter),
        .high_counter   (high_counter),
        .motor_1_out    (motor_1_out),
        .motor_2_out    (motor_2_out),
        .motor_3_out    (motor_3_out),
        .motor_4_out    (motor_4_out),
        .frame_start    (frame_start),
        .state_out      (state_out)
    );

    always #5 us_clk = ~us_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Reference model: cycles since reset release, plus frame-level state.
    int m_t     = 0;
    int m_state = 0;
    int m_miss  = 0;
    bit m_ack   = 1'b0;
    bit m_was_armed;
    int m_sh[4];

    function automatic int clamp_val(input int v);
        return (v > SPAN) ? SPAN : v;
    endfunction

    function automatic int exp_hc(input int pc);
        if (pc <= MIN_US) return 0;
        if (pc <= MAX_US) return pc - MIN_US;
        return SPAN;
    endfunction

    function automatic int exp_out(input int idx);
        return (m_state == 1) ? m_sh[idx] : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d actual=%0d expected=%0d", name, m_t, act, exp);
        end
    endtask

    always @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            m_t = 0; m_state = 0; m_miss = 0; m_ack = 1'b0;
            for (int i = 0; i < 4; i++) m_sh[i] = 0;
        end else begin
            m_t++;
            m_ack = 1'b0;
            if ((m_t % FRAME) == PERIOD) begin
                m_was_armed = (m_state == 1);
                if (update_req) begin
                    m_ack   = 1'b1;
                    m_sh[0] = clamp_val(int'(v1));
                    m_sh[1] = clamp_val(int'(v2));
                    m_sh[2] = clamp_val(int'(v3));
                    m_sh[3] = clamp_val(int'(v4));
                end
                if (m_was_armed && !update_req) m_miss++;
                else m_miss = 0;
                case (m_state)
                    0: if (arm) m_state = 1;
                    1: begin
                        if (!arm) m_state = 0;
`ifdef PWM_FAILSAFE_EN
                        else if (m_miss >= FS_FRAMES) m_state = 2;
`endif
                    end
                    default: if (!arm) m_state = 0;
                endcase
            end
        end
    end

    // Every cycle out of reset: all outputs against the model.
    always @(negedge us_clk) begin : cmp_blk
        int pc;
        if (cmp_en && resetn) begin
            pc = m_t % FRAME;
            chk("period_counter", 32'(period_counter), pc);
            chk("high_counter",   32'(high_counter), exp_hc(pc));
            chk("frame_start",    32'(frame_start), (pc == 0) ? 1 : 0);
            chk("update_ack",     32'(update_ack), 32'(m_ack));
            chk("state_out",      32'(state_out), m_state);
            chk("motor_1_out",    32'(motor_1_out), exp_out(0));
            chk("motor_2_out",    32'(motor_2_out), exp_out(1));
            chk("motor_3_out",    32'(motor_3_out), exp_out(2));
            chk("motor_4_out",    32'(motor_4_out), exp_out(3));
        end
    end

    // Advance to model cycle t_end; the requester drops update_req at the frame start after a boundary.
    task automatic run_until(input int t_end, input bit rnd_arm, input bit rnd_req);
        int guard;
        guard = 0;
        while ((m_t < t_end) && (guard < 30000)) begin
            @(posedge us_clk);
            #1;
            guard++;
            if (update_req && ((m_t % FRAME) == 0)) update_req = 1'b0;
            if (rnd_arm && ($urandom_range(1999, 0) == 0)) arm = ~arm;
            if (rnd_req && !update_req && ($urandom_range(2999, 0) == 0)) begin
                update_req = 1'b1;
                v1 = W'($urandom_range(1023, 0));
                v2 = W'($urandom_range(1023, 0));
                v3 = W'($urandom_range(1023, 0));
                v4 = W'($urandom_range(1023, 0));
            end
        end
        chk("run_until_reached", 32'(m_t), t_end);
    endtask

    task automatic chk_outs(input string tag, input int e1, input int e2, input int e3, input int e4);
        chk({tag, "_m1"}, 32'(motor_1_out), e1);
        chk({tag, "_m2"}, 32'(motor_2_out), e2);
        chk({tag, "_m3"}, 32'(motor_3_out), e3);
        chk({tag, "_m4"}, 32'(motor_4_out), e4);
    endtask

    initial begin
        repeat (3) @(posedge us_clk);
        #1;
        chk("rst_pc", 32'(period_counter), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_state", 32'(state_out), 0);
        resetn = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("rel_pc", 32'(period_counter), 0);
        chk("rel_fs", 32'(frame_start), 1);

        run_until(1000, 0, 0);  chk("hc_1000", 32'(high_counter), 0);
        run_until(1001, 0, 0);  chk("hc_1001", 32'(high_counter), 1);
        run_until(2000, 0, 0);  chk("hc_2000", 32'(high_counter), 1000);
        run_until(10000, 0, 0);
        arm = 1'b1; update_req = 1'b1;
        v1 = 10'd500; v2 = 10'd0; v3 = 10'd1000; v4 = 10'd1023;
        run_until(19999, 0, 0);
        chk("hc_19999", 32'(high_counter), 1000);
        chk("arm_midframe_state", 32'(state_out), 0);
        chk_outs("disarmed_outs", 0, 0, 0, 0);
        run_until(20000, 0, 0);
        chk("ack_at_boundary", 32'(update_ack), 1);
        chk("ack_pc", 32'(period_counter), 20000);
        chk("armed_state", 32'(state_out), 1);
        chk_outs("armed_outs", 500, 0, 1000, 1000);
        run_until(20001, 0, 0);
        chk("fs_20001", 32'(frame_start), 1);
        chk("ack_one_cycle", 32'(update_ack), 0);

        run_until(25001, 0, 0);
        arm = 1'b0;
        run_until(28001, 0, 0);
        update_req = 1'b1;
        v1 = 10'd1001; v2 = 10'd999; v3 = 10'd1; v4 = 10'd0;
        run_until(40000, 0, 0);
        chk("disarm_pending_state", 32'(state_out), 1);
        chk_outs("disarm_pending_outs", 500, 0, 1000, 1000);
        run_until(40001, 0, 0);
        chk("disarm_state", 32'(state_out), 0);
        chk("disarm_ack", 32'(update_ack), 1);
        chk_outs("disarm_outs", 0, 0, 0, 0);
        run_until(40002, 0, 0);
        chk("fs_40002", 32'(frame_start), 1);

        run_until(40102, 0, 0);
        arm = 1'b1;
        run_until(59002, 1, 0);
        arm = 1'b1;
        run_until(60002, 0, 0);
        chk("rearm_state", 32'(state_out), 1);
        chk_outs("rearm_clamped_outs", 1000, 999, 1, 0);

        run_until(60003 + 12345, 1, 1);
        chk("pre_reset_pc", 32'(period_counter), 12345);
        resetn = 1'b0;
        #1;
        chk("async_rst_pc", 32'(period_counter), 0);
        chk("async_rst_hc", 32'(high_counter), 0);
        chk("async_rst_ack", 32'(update_ack), 0);
        chk("async_rst_fs", 32'(frame_start), 0);
        chk("async_rst_state", 32'(state_out), 0);
        chk_outs("async_rst_outs", 0, 0, 0, 0);
        arm = 1'b0; update_req = 1'b0;
        repeat (2) @(posedge us_clk);
        #1;
        resetn = 1'b1;
        #1;
        chk("rerel_pc0", 32'(period_counter), 0);
        chk("rerel_fs", 32'(frame_start), 1);
        run_until(1, 0, 0);  chk("rerel_pc1", 32'(period_counter), 1);
        run_until(2, 0, 0);  chk("rerel_pc2", 32'(period_counter), 2);

`ifdef PWM_FAILSAFE_EN
        arm = 1'b1;
        run_until(20000, 0, 0);
        chk("fs_armed", 32'(state_out), 1);
        run_until(40001, 0, 0);
        chk("fs_tripped", 32'(state_out), 2);
        chk_outs("fs_outs", 0, 0, 0, 0);
        arm = 1'b0;
        run_until(60002, 0, 0);
        chk("fs_exit", 32'(state_out), 0);
`endif

        @(negedge us_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
